xctcmsg_send_arbiter: RTL and testbench



---
 rtl/xctcmsg_pkg.sv | 25 ++
 rtl/xctcmsg_send_arbiter_rr_arbiter.sv | 42 ++++
 rtl/xctcmsg_send_arbiter.sv | 144 ++++++++++++++
 tb/tb_xctcmsg_send_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xctcmsg_pkg.sv
// xctcmsg_pkg
// Shared types and width constants for the XCTCMSG message unit.
// The send arbiter FSM state encoding lives here, together with the request
// record that a send channel presents and the default field widths.
package xctcmsg_pkg;

    localparam int XCTCMSG_ADDR_W = 32;
    localparam int XCTCMSG_TAG_W  = 32;
    localparam int XCTCMSG_MSG_W  = 64;

    // Holding register status of the send arbiter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        LB   = 2'd2
    } send_arb_state_t;

    // One request as seen on a send channel at default widths
    typedef struct packed {
        logic [XCTCMSG_ADDR_W-1:0] dst;
        logic [XCTCMSG_TAG_W-1:0]  tag;
        logic [XCTCMSG_MSG_W-1:0]  msg;
    } arb_req_t;

endpackage

// File: rtl/xctcmsg_send_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The channel at index 'ptr' has
// the highest priority, then ptr+1, ... wrapping modulo N.
// Ports:
//   req     in  N     request bits
//   ptr     in  CH_W  highest-priority index (expected < N)
//   en      in  1     when low no grant is issued
//   gnt     out N     one-hot grant (all zero when nothing granted)
//   gnt_idx out CH_W  index of the granted channel (0 when nothing granted)
module rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [CH_W-1:0] gnt_idx
);

    // Walk the channels starting at ptr; the first requester found wins.
    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/xctcmsg_send_arbiter.sv
// xctcmsg_send_arbiter
// Merges NUM_CHANNELS send requesters onto the single bus send port through a
// round-robin arbiter and one registered holding stage. Messages addressed to
// local_address are diverted to the loopback port when LOOPBACK_EN is set.
// Ports:
//   clk, rst                        clock, async active-high reset
//   flush                           suppresses acceptance this cycle
//   local_address                   this hart's address
//   ch_valid_i / ch_ready_o         per-channel request handshake
//   ch_dst_i / ch_tag_i / ch_msg_i  per-channel request fields
//   bus_val_o / bus_ack_i           bus send handshake
//   bus_dst_o / bus_tag_o / bus_msg_o / bus_ch_o  held message and its channel
//   lb_valid_o / lb_ready_i         loopback handshake
//   lb_src_o / lb_tag_o / lb_msg_o  loopback message (src = latched local_address)
module xctcmsg_send_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = XCTCMSG_ADDR_W,
    parameter int TAG_W        = XCTCMSG_TAG_W,
    parameter int MSG_W        = XCTCMSG_MSG_W,
    parameter int LOOPBACK_EN  = 1,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [ADDR_W-1:0]                    local_address,
    input  logic [NUM_CHANNELS-1:0]              ch_valid_i,
    output logic [NUM_CHANNELS-1:0]              ch_ready_o,
    input  logic [NUM_CHANNELS-1:0][ADDR_W-1:0]  ch_dst_i,
    input  logic [NUM_CHANNELS-1:0][TAG_W-1:0]   ch_tag_i,
    input  logic [NUM_CHANNELS-1:0][MSG_W-1:0]   ch_msg_i,
    output logic                                 bus_val_o,
    input  logic                                 bus_ack_i,
    output logic [ADDR_W-1:0]                    bus_dst_o,
    output logic [TAG_W-1:0]                     bus_tag_o,
    output logic [MSG_W-1:0]                     bus_msg_o,
    output logic [CH_W-1:0]                      bus_ch_o,
    output logic                                 lb_valid_o,
    input  logic                                 lb_ready_i,
    output logic [ADDR_W-1:0]                    lb_src_o,
    output logic [TAG_W-1:0]                     lb_tag_o,
    output logic [MSG_W-1:0]                     lb_msg_o
);

    send_arb_state_t state_q, state_d;

    logic [CH_W-1:0]   rr_ptr_q;
    logic [ADDR_W-1:0] dst_q;
    logic [TAG_W-1:0]  tag_q;
    logic [MSG_W-1:0]  msg_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] src_q;

    logic                    accept_en;
    logic                    accept;
    logic                    done;
    logic                    is_lb;
    logic [NUM_CHANNELS-1:0] gnt;
    logic [CH_W-1:0]         gnt_idx;
    logic [ADDR_W-1:0]       win_dst;
    logic [CH_W-1:0]         rr_ptr_next;

    // The holding register frees up in the same cycle its handshake completes,
    // which is what allows one message per cycle under continuous ack.
    always_comb begin
        done      = ((state_q == BUS) && bus_ack_i) || ((state_q == LB) && lb_ready_i);
        accept_en = !flush && ((state_q == IDLE) || done);
    end

    rr_arbiter #(
        .N    (NUM_CHANNELS),
        .CH_W (CH_W)
    ) u_rr_arbiter (
        .req     (ch_valid_i),
        .ptr     (rr_ptr_q),
        .en      (accept_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Winner decode; gnt is already gated by accept_en.
    always_comb begin
        accept      = |gnt;
        win_dst     = ch_dst_i[gnt_idx];
        is_lb       = (LOOPBACK_EN != 0) && (win_dst == local_address);
        ch_ready_o  = gnt;
        rr_ptr_next = (gnt_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + CH_W'(1);
    end

    // A new acceptance always overrides the return to IDLE on completion.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = is_lb ? LB : BUS;
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= rr_ptr_next;
            end
        end
    end

    // Holding register only loads on acceptance, so fields stay put while a
    // message waits for its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q <= '0;
            tag_q <= '0;
            msg_q <= '0;
            ch_q  <= '0;
            src_q <= '0;
        end else if (accept) begin
            dst_q <= win_dst;
            tag_q <= ch_tag_i[gnt_idx];
            msg_q <= ch_msg_i[gnt_idx];
            ch_q  <= gnt_idx;
            src_q <= local_address;
        end
    end

    always_comb begin
        bus_val_o  = (state_q == BUS);
        lb_valid_o = (state_q == LB);
        bus_dst_o  = dst_q;
        bus_tag_o  = tag_q;
        bus_msg_o  = msg_q;
        bus_ch_o   = ch_q;
        lb_src_o   = src_q;
        lb_tag_o   = tag_q;
        lb_msg_o   = msg_q;
    end

endmodule

// File: tb/tb_xctcmsg_send_arbiter.sv
// tb_xctcmsg_send_arbiter
// Directed bench for the send arbiter. Two instances share all inputs: one
// with loopback enabled (main DUT) and one with loopback disabled, used to
// show that self-addressed traffic goes to the bus when loopback is off.
module tb_xctcmsg_send_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int TW = 32;
    localparam int MW = 64;
    localparam int CW = 2;

    logic clk;
    logic rst;
    logic flush;
    logic [AW-1:0] local_address;
    logic [NC-1:0] ch_valid_i;
    logic [NC-1:0][AW-1:0] ch_dst_i;
    logic [NC-1:0][TW-1:0] ch_tag_i;
    logic [NC-1:0][MW-1:0] ch_msg_i;
    logic bus_ack_i;
    logic lb_ready_i;

    logic [NC-1:0] ch_ready_o;
    logic          bus_val_o;
    logic [AW-1:0] bus_dst_o;
    logic [TW-1:0] bus_tag_o;
    logic [MW-1:0] bus_msg_o;
    logic [CW-1:0] bus_ch_o;
    logic          lb_valid_o;
    logic [AW-1:0] lb_src_o;
    logic [TW-1:0] lb_tag_o;
    logic [MW-1:0] lb_msg_o;

    logic [NC-1:0] nl_ch_ready_o;
    logic          nl_bus_val_o;
    logic [AW-1:0] nl_bus_dst_o;
    logic [TW-1:0] nl_bus_tag_o;
    logic [MW-1:0] nl_bus_msg_o;
    logic [CW-1:0] nl_bus_ch_o;
    logic          nl_lb_valid_o;
    logic [AW-1:0] nl_lb_src_o;
    logic [TW-1:0] nl_lb_tag_o;
    logic [MW-1:0] nl_lb_msg_o;

    int testCount = 0;
    int failCount = 0;

    xctcmsg_send_arbiter #(.NUM_CHANNELS(NC), .ADDR_W(AW), .TAG_W(TW), .MSG_W(MW), .LOOPBACK_EN(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .local_address(local_address),
        .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
        .ch_dst_i(ch_dst_i), .ch_tag_i(ch_tag_i), .ch_msg_i(ch_msg_i),
        .bus_val_o(bus_val_o), .bus_ack_i(bus_ack_i),
        .bus_dst_o(bus_dst_o), .bus_tag_o(bus_tag_o), .bus_msg_o(bus_msg_o), .bus_ch_o(bus_ch_o),
        .lb_valid_o(lb_valid_o), .lb_ready_i(lb_ready_i),
        .lb_src_o(lb_src_o), .lb_tag_o(lb_tag_o), .lb_msg_o(lb_msg_o)
    );

    xctcmsg_send_arbiter #(.NUM_CHANNELS(NC), .ADDR_W(AW), .TAG_W(TW), .MSG_W(MW), .LOOPBACK_EN(0)) dut_nolb (
        .clk(clk), .rst(rst), .flush(flush), .local_address(local_address),
        .ch_valid_i(ch_valid_i), .ch_ready_o(nl_ch_ready_o),
        .ch_dst_i(ch_dst_i), .ch_tag_i(ch_tag_i), .ch_msg_i(ch_msg_i),
        .bus_val_o(nl_bus_val_o), .bus_ack_i(bus_ack_i),
        .bus_dst_o(nl_bus_dst_o), .bus_tag_o(nl_bus_tag_o), .bus_msg_o(nl_bus_msg_o), .bus_ch_o(nl_bus_ch_o),
        .lb_valid_o(nl_lb_valid_o), .lb_ready_i(lb_ready_i),
        .lb_src_o(nl_lb_src_o), .lb_tag_o(nl_lb_tag_o), .lb_msg_o(nl_lb_msg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the handshake-related inputs in one go
    task automatic applyStimulus(input logic [NC-1:0] valid, input logic fl,
                                 input logic ack, input logic lbr);
        ch_valid_i = valid;
        flush      = fl;
        bus_ack_i  = ack;
        lb_ready_i = lbr;
        #1;
    endtask

    // Compare one observed value against its hand-derived expectation
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        local_address = 32'h2;
        ch_dst_i[0] = 32'h10; ch_dst_i[1] = 32'h5; ch_dst_i[2] = 32'h7; ch_dst_i[3] = 32'h9;
        for (int i = 0; i < NC; i++) begin
            ch_tag_i[i] = 32'hA0 + i;
            ch_msg_i[i] = 64'h1000_0000_0000_0000 + i;
        end
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset state
        stepCycle();
        checkOutput("rst_bus_val", bus_val_o, 0);
        checkOutput("rst_lb_valid", lb_valid_o, 0);
        checkOutput("rst_ch_ready", ch_ready_o, 0);
        checkOutput("rst_bus_dst", bus_dst_o, 0);
        checkOutput("rst_bus_msg", bus_msg_o, 0);
        checkOutput("rst_bus_ch", bus_ch_o, 0);
        checkOutput("rst_lb_src", lb_src_o, 0);
        rst = 1'b0;
        stepCycle();

        // Single send with delayed ack
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
        checkOutput("single_ready", ch_ready_o, 4'b0010);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("single_ready_drop", ch_ready_o, 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("single_bus_val", bus_val_o, 1);
            checkOutput("single_bus_dst", bus_dst_o, 32'h5);
            checkOutput("single_bus_tag", bus_tag_o, 32'hA1);
            checkOutput("single_bus_ch", bus_ch_o, 1);
            checkOutput("single_lb_valid", lb_valid_o, 0);
            stepCycle();
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("single_idle", bus_val_o, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        // Fresh pointer for the fairness sequence
        rst = 1'b1;
        #1;
        rst = 1'b0;
        stepCycle();

        // Fairness: all valid, ack every cycle
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("fair_ready", ch_ready_o, 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                checkOutput("fair_bus_val", bus_val_o, 1);
                checkOutput("fair_bus_ch", bus_ch_o, 64'((k - 1) % 4));
                checkOutput("fair_bus_dst", bus_dst_o, ch_dst_i[(k - 1) % 4]);
            end
            stepCycle();
        end
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("fair_drain", bus_val_o, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        // Loopback: pointer is now 2, ch2 addresses this hart
        ch_dst_i[2] = 32'h2;
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
        checkOutput("lb_ready", ch_ready_o, 4'b0100);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("lb_valid", lb_valid_o, 1);
        checkOutput("lb_bus_val", bus_val_o, 0);
        checkOutput("lb_src", lb_src_o, 32'h2);
        checkOutput("lb_tag", lb_tag_o, 32'hA2);
        checkOutput("lb_msg", lb_msg_o, 64'h1000_0000_0000_0002);
        checkOutput("nolb_bus_val", nl_bus_val_o, 1);
        checkOutput("nolb_lb_valid", nl_lb_valid_o, 0);
        checkOutput("nolb_bus_dst", nl_bus_dst_o, 32'h2);
        // Stray bus ack while in LB is ignored
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("lb_stray_ack", lb_valid_o, 1);
        checkOutput("nolb_done", nl_bus_val_o, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("lb_done", lb_valid_o, 0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

        // Flush: pointer is 3; hold ch3 on the bus first
        applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_ready", ch_ready_o, 4'b1000);
        stepCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_block", ch_ready_o, 0);
        stepCycle();
        checkOutput("flush_hold_val", bus_val_o, 1);
        checkOutput("flush_hold_ch", bus_ch_o, 3);
        checkOutput("flush_hold_dst", bus_dst_o, 32'h9);
        applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_ack_block", ch_ready_o, 0);
        stepCycle();
        checkOutput("flush_complete", bus_val_o, 0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_release", ch_ready_o, 4'b0001);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_new_val", bus_val_o, 1);
        checkOutput("flush_new_ch", bus_ch_o, 0);

        // Reset mid-transfer: pointer is 1 before reset, 0 after
        rst = 1'b1;
        #1;
        checkOutput("midrst_bus_val", bus_val_o, 0);
        checkOutput("midrst_bus_dst", bus_dst_o, 0);
        rst = 1'b0;
        stepCycle();
        applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_ptr", ch_ready_o, 4'b0001);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_ch", bus_ch_o, 0);

        // Same-cycle ack and accept
        applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
        checkOutput("ackacc_ready", ch_ready_o, 4'b1000);
        checkOutput("ackacc_val_before", bus_val_o, 1);
        stepCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
        checkOutput("ackacc_val_after", bus_val_o, 1);
        checkOutput("ackacc_ch", bus_ch_o, 3);
        checkOutput("ackacc_dst", bus_dst_o, 32'h9);
        checkOutput("ackacc_msg", bus_msg_o, 64'h1000_0000_0000_0003);
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
        stepCycle();
        checkOutput("ackacc_idle", bus_val_o, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
